// File: rtl/idu_alloc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// idu_alloc_ctrl_pkg
// Shared defaults for the decode-stage allocation controller: IID window width,
// physical register count/width, architectural register count and the derived
// free-list depth. The controller and its free list take these as parameter
// defaults.
// -----------------------------------------------------------------------------
package idu_alloc_ctrl_pkg;

    localparam int IDU_IID_W    = 6;
    localparam int IDU_PREG_NUM = 64;
    localparam int IDU_PREG_W   = 6;
    localparam int IDU_ARCH_NUM = 32;
    localparam int IDU_FL_DEPTH = IDU_PREG_NUM - IDU_ARCH_NUM;

    // Free-list capacity: every preg above the architectural set is free at reset.
    function automatic int fl_depth(input int preg_num, input int arch_num);
        return preg_num - arch_num;
    endfunction

endpackage

// File: rtl/idu_preg_freelist.sv
// -----------------------------------------------------------------------------
// idu_preg_freelist
// Circular physical-register free list with a speculative read pointer, a
// committed read pointer and a write pointer. Pointers carry one extra lap bit
// and wrap at twice the capacity so that full and empty are distinguishable.
//
// Ports:
//   clk, rst_clk     clock, synchronous active-high reset
//   flush_i          restore the speculative read pointer to the committed one
//   grant_i          a preg is handed out this cycle
//   release_i        a retiring instruction returns release_preg_i
//   release_preg_i   preg returned to the list
//   grant_preg_o     preg at the speculative read pointer
//   free_cnt_o       pregs available for speculative allocation
//   avail_o          free_cnt_o is non-zero
// -----------------------------------------------------------------------------
module idu_preg_freelist
    import idu_alloc_ctrl_pkg::*;
#(
    parameter int PREG_NUM = IDU_PREG_NUM,
    parameter int PREG_W   = IDU_PREG_W,
    parameter int ARCH_NUM = IDU_ARCH_NUM
) (
    input  logic              clk,
    input  logic              rst_clk,
    input  logic              flush_i,
    input  logic              grant_i,
    input  logic              release_i,
    input  logic [PREG_W-1:0] release_preg_i,
    output logic [PREG_W-1:0] grant_preg_o,
    output logic [PREG_W:0]   free_cnt_o,
    output logic              avail_o
);

    localparam int              FL_DEPTH = fl_depth(PREG_NUM, ARCH_NUM);
    localparam int              IDX_W    = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;
    localparam logic [PREG_W:0] DEPTH_P  = (PREG_W+1)'(FL_DEPTH);
    localparam logic [PREG_W:0] DEPTH2_P = (PREG_W+1)'(2 * FL_DEPTH);
    localparam logic [PREG_W:0] PTR_MAX  = (PREG_W+1)'(2 * FL_DEPTH - 1);

    // Pointers count 0..2*FL_DEPTH-1, then wrap.
    function automatic logic [PREG_W:0] ptr_inc(input logic [PREG_W:0] p);
        if (p == PTR_MAX) begin
            return '0;
        end else begin
            return p + {{PREG_W{1'b0}}, 1'b1};
        end
    endfunction

    // Drop the lap bit: fold the pointer back into the array range.
    function automatic logic [IDX_W-1:0] ptr_idx(input logic [PREG_W:0] p);
        logic [PREG_W:0] m;
        m = (p >= DEPTH_P) ? (p - DEPTH_P) : p;
        return m[IDX_W-1:0];
    endfunction

    logic [PREG_W-1:0] fl_q [FL_DEPTH];
    logic [PREG_W:0]   spec_rd_q, spec_rd_d;
    logic [PREG_W:0]   cmt_rd_q,  cmt_rd_d;
    logic [PREG_W:0]   wr_q,      wr_d;
    logic [PREG_W:0]   diff_s;

    // Next-pointer logic; a flush lands on the committed pointer after this
    // cycle's retire has been applied.
    always_comb begin
        cmt_rd_d = release_i ? ptr_inc(cmt_rd_q) : cmt_rd_q;
        wr_d     = release_i ? ptr_inc(wr_q)     : wr_q;
        if (flush_i) begin
            spec_rd_d = cmt_rd_d;
        end else if (grant_i) begin
            spec_rd_d = ptr_inc(spec_rd_q);
        end else begin
            spec_rd_d = spec_rd_q;
        end
    end

    // Free count is the modular distance from the speculative read to the write pointer.
    always_comb begin
        diff_s = wr_q - spec_rd_q;
        if (wr_q >= spec_rd_q) begin
            free_cnt_o = diff_s;
        end else begin
            free_cnt_o = diff_s + DEPTH2_P;
        end
        avail_o      = (free_cnt_o != '0);
        grant_preg_o = fl_q[ptr_idx(spec_rd_q)];
    end

    // Pointer and array state; reset fills the list with ARCH_NUM..PREG_NUM-1.
    always_ff @(posedge clk) begin
        if (rst_clk) begin
            spec_rd_q <= '0;
            cmt_rd_q  <= '0;
            wr_q      <= DEPTH_P;
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_q[i] <= PREG_W'(ARCH_NUM + i);
            end
        end else begin
            spec_rd_q <= spec_rd_d;
            cmt_rd_q  <= cmt_rd_d;
            wr_q      <= wr_d;
            if (release_i) begin
                fl_q[ptr_idx(wr_q)] <= release_preg_i;
            end
        end
    end

endmodule

// File: rtl/idu_alloc_ctrl.sv
// -----------------------------------------------------------------------------
// idu_alloc_ctrl
// Decode-stage allocation controller. Grants an IID to every valid decoded
// instruction and a physical register to every instruction with a destination,
// and stalls decode when a resource is exhausted or dispatch is not ready.
// Grants are combinational from inputs and registered pointers.
//
// Ports:
//   clk, rst_clk            clock, synchronous active-high reset
//   rtu_global_flush        discard all speculative allocations
//   iid_req / preg_req      decoder request / destination preg needed
//   dis_ready               dispatch accepts this cycle
//   rtu_retire_vld          oldest instruction retires
//   rtu_retire_dst_vld      retiring instruction had a preg
//   rtu_retire_old_preg     previous mapping returned to the free list
//   alloc_vld, alloc_iid    grant fired, granted IID (with wrap bit)
//   alloc_preg_vld/_preg    preg grant fired, granted preg
//   y_idu_id_stall_ctrl     hold decode
//   iid_free_cnt            free IID entries
//   preg_free_cnt           free pregs for speculative allocation
//
// Optional: define IDU_ALLOC_ASSERT_EN for simulation-only protocol checks.
// -----------------------------------------------------------------------------
module idu_alloc_ctrl
    import idu_alloc_ctrl_pkg::*;
#(
    parameter int IID_W    = IDU_IID_W,
    parameter int PREG_NUM = IDU_PREG_NUM,
    parameter int PREG_W   = IDU_PREG_W,
    parameter int ARCH_NUM = IDU_ARCH_NUM
) (
    input  logic              clk,
    input  logic              rst_clk,
    input  logic              rtu_global_flush,
    input  logic              iid_req,
    input  logic              preg_req,
    input  logic              dis_ready,
    input  logic              rtu_retire_vld,
    input  logic              rtu_retire_dst_vld,
    input  logic [PREG_W-1:0] rtu_retire_old_preg,
    output logic              alloc_vld,
    output logic [IID_W:0]    alloc_iid,
    output logic              alloc_preg_vld,
    output logic [PREG_W-1:0] alloc_preg,
    output logic              y_idu_id_stall_ctrl,
    output logic [IID_W:0]    iid_free_cnt,
    output logic [PREG_W:0]   preg_free_cnt
);

    localparam logic [IID_W:0] WIN_SIZE = {1'b1, {IID_W{1'b0}}};

    logic [IID_W:0]    head_q, head_d;
    logic [IID_W:0]    tail_q, tail_d;
    logic [IID_W:0]    inflight_s;
    logic              iid_avail_s;
    logic              preg_avail_s;
    logic              fire_s;
    logic              preg_grant_s;
    logic              preg_release_s;
    logic [PREG_W-1:0] fl_preg_s;
    logic [PREG_W:0]   fl_cnt_s;

    idu_preg_freelist #(
        .PREG_NUM (PREG_NUM),
        .PREG_W   (PREG_W),
        .ARCH_NUM (ARCH_NUM)
    ) u_freelist (
        .clk            (clk),
        .rst_clk        (rst_clk),
        .flush_i        (rtu_global_flush),
        .grant_i        (preg_grant_s),
        .release_i      (preg_release_s),
        .release_preg_i (rtu_retire_old_preg),
        .grant_preg_o   (fl_preg_s),
        .free_cnt_o     (fl_cnt_s),
        .avail_o        (preg_avail_s)
    );

    // Fire decision; in-flight never exceeds the window, so its MSB alone marks "full".
    always_comb begin
        inflight_s     = head_q - tail_q;
        iid_avail_s    = ~inflight_s[IID_W];
        fire_s         = iid_req & dis_ready & iid_avail_s & (~preg_req | preg_avail_s)
                         & ~rtu_global_flush;
        preg_grant_s   = fire_s & preg_req;
        preg_release_s = rtu_retire_vld & rtu_retire_dst_vld;
    end

    // Window pointers; a flush moves head onto the post-retire tail.
    always_comb begin
        tail_d = rtu_retire_vld ? (tail_q + {{IID_W{1'b0}}, 1'b1}) : tail_q;
        if (rtu_global_flush) begin
            head_d = tail_d;
        end else if (fire_s) begin
            head_d = head_q + {{IID_W{1'b0}}, 1'b1};
        end else begin
            head_d = head_q;
        end
    end

    // Output drive; everything is held at zero while reset is asserted.
    always_comb begin
        if (rst_clk) begin
            alloc_vld           = 1'b0;
            alloc_iid           = '0;
            alloc_preg_vld      = 1'b0;
            alloc_preg          = '0;
            y_idu_id_stall_ctrl = 1'b0;
            iid_free_cnt        = '0;
            preg_free_cnt       = '0;
        end else begin
            alloc_vld           = fire_s;
            alloc_iid           = head_q;
            alloc_preg_vld      = preg_grant_s;
            alloc_preg          = fl_preg_s;
            y_idu_id_stall_ctrl = iid_req & ~fire_s & ~rtu_global_flush;
            iid_free_cnt        = WIN_SIZE - inflight_s;
            preg_free_cnt       = fl_cnt_s;
        end
    end

    // IID window state.
    always_ff @(posedge clk) begin
        if (rst_clk) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

`ifdef IDU_ALLOC_ASSERT_EN
    localparam logic [PREG_W:0] ARCH_P = (PREG_W+1)'(ARCH_NUM);
    localparam logic [PREG_W:0] FL_P   = (PREG_W+1)'(fl_depth(PREG_NUM, ARCH_NUM));

    // Outstanding grants of low pregs; cleared by release, and by flush since
    // reclaimed grants are legitimately handed out again.
    logic [PREG_NUM-1:0] granted_q;

    // Protocol checks on retire, release and duplicate low-preg grants.
    always_ff @(posedge clk) begin
        if (rst_clk) begin
            granted_q <= '0;
        end else if (rtu_global_flush) begin
            granted_q <= '0;
        end else begin
            if (rtu_retire_vld && (inflight_s == '0)) begin
                $error("idu_alloc_ctrl: retire with empty IID window");
            end
            if (preg_release_s && !preg_grant_s && (fl_cnt_s == FL_P)) begin
                $error("idu_alloc_ctrl: release into full free list");
            end
            if (preg_release_s) begin
                granted_q[rtu_retire_old_preg] <= 1'b0;
            end
            if (preg_grant_s && ({1'b0, fl_preg_s} < ARCH_P)) begin
                if (granted_q[fl_preg_s]) begin
                    $error("idu_alloc_ctrl: preg %0d granted twice", fl_preg_s);
                end
                granted_q[fl_preg_s] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_idu_alloc_ctrl.sv
module tb_idu_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst_clk;
    logic       rtu_global_flush;
    logic       iid_req;
    logic       preg_req;
    logic       dis_ready;
    logic       rtu_retire_vld;
    logic       rtu_retire_dst_vld;
    logic [5:0] rtu_retire_old_preg;
    logic       alloc_vld;
    logic [6:0] alloc_iid;
    logic       alloc_preg_vld;
    logic [5:0] alloc_preg;
    logic       y_idu_id_stall_ctrl;
    logic [6:0] iid_free_cnt;
    logic [6:0] preg_free_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       vld;
        logic       pvld;
        logic       stall;
        logic       ids;
        logic [6:0] iid;
        logic [5:0] preg;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    idu_alloc_ctrl dut (
        .clk                 (clk),
        .rst_clk             (rst_clk),
        .rtu_global_flush    (rtu_global_flush),
        .iid_req             (iid_req),
        .preg_req            (preg_req),
        .dis_ready           (dis_ready),
        .rtu_retire_vld      (rtu_retire_vld),
        .rtu_retire_dst_vld  (rtu_retire_dst_vld),
        .rtu_retire_old_preg (rtu_retire_old_preg),
        .alloc_vld           (alloc_vld),
        .alloc_iid           (alloc_iid),
        .alloc_preg_vld      (alloc_preg_vld),
        .alloc_preg          (alloc_preg),
        .y_idu_id_stall_ctrl (y_idu_id_stall_ctrl),
        .iid_free_cnt        (iid_free_cnt),
        .preg_free_cnt       (preg_free_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, push expectation, pop and compare 2 time units later.
    task automatic go(input logic rq, input logic prq, input logic dr,
                      input logic rv, input logic rdv, input logic [5:0] op, input logic fl,
                      input logic ev, input logic epv, input logic es,
                      input logic ids, input logic [6:0] ei, input logic [5:0] ep,
                      input string tag);
        exp_t e;
        @(negedge clk);
        iid_req = rq; preg_req = prq; dis_ready = dr;
        rtu_retire_vld = rv; rtu_retire_dst_vld = rdv; rtu_retire_old_preg = op;
        rtu_global_flush = fl;
        e.vld = ev; e.pvld = epv; e.stall = es; e.ids = ids; e.iid = ei; e.preg = ep; e.tag = tag;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        chk({e.tag, ".vld"},   32'(alloc_vld),           32'(e.vld));
        chk({e.tag, ".pvld"},  32'(alloc_preg_vld),      32'(e.pvld));
        chk({e.tag, ".stall"}, 32'(y_idu_id_stall_ctrl), 32'(e.stall));
        if (e.ids) begin
            chk({e.tag, ".iid"},  32'(alloc_iid),  32'(e.iid));
            chk({e.tag, ".preg"}, 32'(alloc_preg), 32'(e.preg));
        end
    endtask

    // Idle cycle that also checks the free counts.
    task automatic idle(input logic [6:0] eic, input logic [6:0] epc, input string tag);
        go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 6'd0, tag);
        chk({tag, ".iid_cnt"},  32'(iid_free_cnt),  32'(eic));
        chk({tag, ".preg_cnt"}, 32'(preg_free_cnt), 32'(epc));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_clk = 1'b1;
        iid_req = 1'b1; preg_req = 1'b1; dis_ready = 1'b1;
        rtu_retire_vld = 1'b0; rtu_retire_dst_vld = 1'b0; rtu_retire_old_preg = 6'd0;
        rtu_global_flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #2;
            chk("rst.vld",      32'(alloc_vld),           32'd0);
            chk("rst.stall",    32'(y_idu_id_stall_ctrl), 32'd0);
            chk("rst.iid",      32'(alloc_iid),           32'd0);
            chk("rst.preg",     32'(alloc_preg),          32'd0);
            chk("rst.iid_cnt",  32'(iid_free_cnt),        32'd0);
            chk("rst.preg_cnt", 32'(preg_free_cnt),       32'd0);
            @(negedge clk);
        end
        rst_clk = 1'b0;
        iid_req = 1'b0; preg_req = 1'b0; dis_ready = 1'b0;
    endtask

    // preg-needing grant expected to fire with the given IID/preg
    task automatic grant_p(input logic [6:0] ei, input logic [5:0] ep, input string tag);
        go(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, ei, ep, tag);
    endtask

    initial begin
        // T1: first grant after reset, plus no-dispatch and no-request cases
        do_reset();
        idle(7'd64, 7'd32, "t1_rst_cnt");
        go(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 6'd32, "t1_nodis");
        grant_p(7'd0, 6'd32, "t1_grant");
        idle(7'd63, 7'd31, "t1_cnt");

        // T2: drain the free list
        do_reset();
        for (int i = 0; i < 32; i++) begin
            grant_p(7'(i), 6'(32 + i), "t2_grant");
        end
        idle(7'd32, 7'd0, "t2_cnt");
        go(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd32, 6'd32, "t2_stall");
        go(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd32, 6'd32, "t2_nopreg");

        // T3: fill the IID window, retire one, wrap-bit IID next cycle
        do_reset();
        for (int i = 0; i < 64; i++) begin
            go(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'(i), 6'd32, "t3_grant");
        end
        go(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd64, 6'd32, "t3_full");
        go(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd64, 6'd32, "t3_full_ret");
        go(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1000000, 6'd32, "t3_wrap");
        idle(7'd0, 7'd32, "t3_cnt");

        // T4: flush reclaims speculative grants
        do_reset();
        for (int i = 0; i < 5; i++) begin
            grant_p(7'(i), 6'(32 + i), "t4_grant");
        end
        go(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'd5, 6'd37, "t4_flush");
        idle(7'd64, 7'd32, "t4_cnt");
        grant_p(7'd0, 6'd32, "t4_regrant");

        // T5: empty list, release of preg 3 becomes grantable next cycle
        do_reset();
        for (int i = 0; i < 32; i++) begin
            grant_p(7'(i), 6'(32 + i), "t5_grant");
        end
        go(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd32, 6'd32, "t5_rel");
        idle(7'd33, 7'd1, "t5_cnt");
        grant_p(7'd32, 6'd3, "t5_reuse");
        idle(7'd32, 7'd0, "t5_cnt2");

        // T6: flush with same-cycle retire of IID 0 releasing preg 5
        do_reset();
        for (int i = 0; i < 3; i++) begin
            grant_p(7'(i), 6'(32 + i), "t6_grant");
        end
        go(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'd3, 6'd35, "t6_flush");
        idle(7'd64, 7'd32, "t6_cnt");
        grant_p(7'd1, 6'd33, "t6_regrant");
        idle(7'd63, 7'd31, "t6_cnt2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
